// File: rtl/xor_arb_pkg.sv
// Shared types for the serial XOR arbiter: FSM encoding and requester IDs.
package xor_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/myxor.sv
// Single-bit XOR cell shared by all requesters.
module myxor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/xor_serial_arbiter.sv
// Round-robin front end that streams two requesters' operand pairs LSB-first
// through one shared 1-bit XOR cell and returns the result with ID and parity.
module xor_serial_arbiter
    import xor_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_id,
    output logic             rsp_parity,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] y_sh_q, y_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;
    req_id_t          id_q, id_d;
    req_id_t          last_id_q, last_id_d;
    logic             grant0, grant1;
    logic             x;

    myxor u_myxor (
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .y (x)
    );

    // On a tie the requester that was not served last wins.
    assign grant0 = req0_valid & (~req1_valid | (last_id_q == REQ1));
    assign grant1 = req1_valid & (~req0_valid | (last_id_q == REQ0));

    assign req0_ready = rst_n & (state_q == IDLE) & grant0;
    assign req1_ready = rst_n & (state_q == IDLE) & grant1;

    assign rsp_valid  = (state_q == DONE);
    assign busy       = (state_q == SHIFT) | (state_q == DONE);
    assign rsp_y      = y_sh_q;
    assign rsp_id     = id_q;
    assign rsp_parity = par_q;

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        y_sh_d    = y_sh_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        case (state_q)
            IDLE: begin
                if (req0_ready | req1_ready) begin
                    a_sh_d    = req1_ready ? req1_a : req0_a;
                    b_sh_d    = req1_ready ? req1_b : req0_b;
                    y_sh_d    = '0;
                    cnt_d     = '0;
                    par_d     = 1'b0;
                    id_d      = req1_ready ? REQ1 : REQ0;
                    last_id_d = req1_ready ? REQ1 : REQ0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                y_sh_d = {x, y_sh_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                par_d  = par_q ^ x;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            y_sh_q    <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            id_q      <= REQ0;
            last_id_q <= REQ1;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            y_sh_q    <= y_sh_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
        end
    end

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Scoreboard bench for xor_serial_arbiter: transaction-level model predicts
// grants, timing and responses; a separate monitor checks every response.
module tb_xor_serial_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_parity, busy;
    logic [W-1:0] rsp_y;

    logic         w4_req0_valid, w4_req0_ready, w4_req1_ready;
    logic [3:0]   w4_a, w4_b, w4_rsp_y;
    logic         w4_rsp_valid, w4_rsp_id, w4_rsp_parity, w4_busy;

    always #5 clk = ~clk;

    xor_serial_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_id(rsp_id), .rsp_parity(rsp_parity), .busy(busy)
    );

    xor_serial_arbiter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w4_req0_valid), .req0_ready(w4_req0_ready), .req0_a(w4_a), .req0_b(w4_b),
        .req1_valid(1'b0), .req1_ready(w4_req1_ready), .req1_a(4'h0), .req1_b(4'h0),
        .rsp_valid(w4_rsp_valid), .rsp_ready(1'b1), .rsp_y(w4_rsp_y),
        .rsp_id(w4_rsp_id), .rsp_parity(w4_rsp_parity), .busy(w4_busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef logic [W+1:0] rsp_t;  // {y, id, parity}
    rsp_t sb[$];
    rsp_t obs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction model: 0 = idle, 1 = shifting (m_left bit-cycles to go), 2 = holding response.
    int m_st = 0;
    int m_left = 0;
    bit m_last = 1'b1;
    bit m_known = 1'b0;
    bit m_rstd = 1'b0;

    always @(negedge clk) begin : model
        bit e0, e1;
        logic [W-1:0] y;
        e0 = 1'b0;
        e1 = 1'b0;
        if (m_known) begin
            if (rst_n && m_st == 0) begin
                if (req0_valid && req1_valid) begin
                    if (m_last) e0 = 1'b1; else e1 = 1'b1;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            chk("req0_ready", 32'(req0_ready), 32'(e0));
            chk("req1_ready", 32'(req1_ready), 32'(e1));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
            chk("busy", 32'(busy), 32'(m_st != 0));
            if (m_rstd) begin
                chk("reset_rsp_y", 32'(rsp_y), 32'd0);
                chk("reset_rsp_parity", 32'(rsp_parity), 32'd0);
                chk("reset_rsp_id", 32'(rsp_id), 32'd0);
            end
        end
        if (!rst_n) begin
            m_st = 0;
            m_last = 1'b1;
            sb.delete();
            m_known = 1'b1;
            m_rstd = 1'b1;
        end else if (m_known) begin
            m_rstd = 1'b0;
            case (m_st)
                0: if (e0 || e1) begin
                    y = e1 ? (req1_a ^ req1_b) : (req0_a ^ req0_b);
                    sb.push_back({y, e1, ^y});
                    m_last = e1;
                    m_st = 1;
                    m_left = W;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_st = 2;
                end
                default: if (rsp_ready) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        rsp_t got;
        if (rst_n && rsp_valid) begin
            got = {rsp_y, rsp_id, rsp_parity};
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rsp_unexpected: got %0h, expected no response (t=%0t)", got, $time);
            end else begin
                chk("rsp", 32'(got), 32'(sb[0]));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    obs.push_back(got);
                end
            end
        end
    end

    bit rand_mode = 1'b0;

    task automatic step();
        bit a0, a1;
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (a0) req0_valid = 1'b0;
        if (a1) req1_valid = 1'b0;
        if (rand_mode) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_a = W'($urandom);
                req0_b = W'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_a = W'($urandom);
                req1_b = W'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain(input int cap);
        int i;
        i = 0;
        while ((req0_valid || req1_valid || sb.size() != 0 || rsp_valid) && i < cap) begin
            step();
            i++;
        end
        chk("drain_done", 32'(i < cap), 32'd1);
    endtask

    task automatic wait_req0_taken(input int cap);
        int i;
        i = 0;
        while (req0_valid && i < cap) begin
            step();
            i++;
        end
        chk("req0_taken", 32'(req0_valid), 32'd0);
    endtask

    initial begin : stim
        int base;
        int i;
        int lat;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h00;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h0F;
        rsp_ready = 1'b1;
        w4_req0_valid = 1'b0; w4_a = 4'h0; w4_b = 4'h0;

        // Reset with both requesters pending, then the tie resolves to req0 first.
        step();
        step();
        rst_n = 1'b1;
        base = obs.size();
        drain(200);
        chk("tie_count", 32'(obs.size() - base), 32'd2);
        if (obs.size() >= base + 2) begin
            chk("tie_first", 32'(obs[base]), 32'({8'h01, 1'b0, 1'b1}));
            chk("tie_second", 32'(obs[base+1]), 32'({8'hF0, 1'b1, 1'b0}));
        end

        req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom);
        req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom);
        base = obs.size();
        drain(200);
        chk("retie_count", 32'(obs.size() - base), 32'd2);
        if (obs.size() >= base + 1) chk("retie_id", 32'(obs[base][1]), 32'd0);

        req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h3C;
        base = obs.size();
        drain(200);
        chk("single_count", 32'(obs.size() - base), 32'd1);
        if (obs.size() >= base + 1) chk("single_rsp", 32'(obs[base]), 32'({8'h99, 1'b0, 1'b0}));

        // Backpressure: hold DONE for 5 cycles while req1 waits.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'h13;
        base = obs.size();
        wait_req0_taken(20);
        req1_valid = 1'b1; req1_a = 8'h77; req1_b = 8'h70;
        repeat (W + 5) step();
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_rsp_y", 32'(rsp_y), 32'(8'h49));
        rsp_ready = 1'b1;
        drain(200);
        chk("stall_count", 32'(obs.size() - base), 32'd2);
        if (obs.size() >= base + 2) begin
            chk("stall_first", 32'(obs[base]), 32'({8'h49, 1'b0, 1'b1}));
            chk("stall_second", 32'(obs[base+1]), 32'({8'h07, 1'b1, 1'b1}));
        end

        // Reset in the middle of SHIFT after bit 3 has been processed.
        req0_valid = 1'b1; req0_a = 8'hC3; req0_b = 8'h81;
        base = obs.size();
        wait_req0_taken(20);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (W + 4) step();
        chk("midreset_no_rsp", 32'(obs.size() - base), 32'd0);
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h00;
        drain(200);
        chk("postreset_count", 32'(obs.size() - base), 32'd1);
        if (obs.size() >= base + 1) chk("postreset_rsp", 32'(obs[base]), 32'({8'hFF, 1'b1, 1'b0}));

        rand_mode = 1'b1;
        repeat (800) step();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        drain(300);

        // WIDTH=4 instance: latency and result.
        w4_req0_valid = 1'b1; w4_a = 4'hA; w4_b = 4'h5;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!w4_req0_ready && i < 10);
        chk("w4_ready", 32'(w4_req0_ready), 32'd1);
        @(posedge clk);
        #1;
        w4_req0_valid = 1'b0;
        lat = 0;
        while (!w4_rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w4_latency", 32'(lat), 32'd4);
        chk("w4_rsp_y", 32'(w4_rsp_y), 32'hF);
        chk("w4_parity", 32'(w4_rsp_parity), 32'd0);
        chk("w4_id", 32'(w4_rsp_id), 32'd0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
